// File: rtl/ahb_seg_display.sv
// AHB-Lite slave that drives a multiplexed 7-segment display.
// Bus writes land in shadow registers. They reach the pins only through a
// COMMIT that waits for a frame boundary, so a frame never mixes old and new digits.
module ahb_seg_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [31:0]           HWDATA,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic                  HSEL,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [7:0]            Seg,
  output logic [NUM_DIGITS-1:0] nDigit
);

  localparam int              PW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]      LAST_DIGIT  = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]      DIGIT_MASK  = 8'((16'd1 << NUM_DIGITS) - 16'd1);

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_BRIGHT  = 3'd2;
  localparam logic [2:0] ADDR_DATA_LO = 3'd4;
  localparam logic [2:0] ADDR_DATA_HI = 3'd5;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bus data-phase state
  logic       r_dp_valid;
  logic       r_dp_write;
  logic [2:0] r_dp_addr;

  // Control and display state
  logic                  r_en;
  logic [7:0]            r_hexmask;
  logic [3:0]            r_bright;
  logic                  r_pending;
  logic [7:0]            r_shadow [NUM_DIGITS];
  logic [7:0]            r_active [NUM_DIGITS];
  logic [PW-1:0]         r_presc;
  logic [2:0]            r_index;
  logic [3:0]            r_pwm;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_ndigit;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wrap;
  logic                  w_commit;
  logic                  w_on;
  logic [7:0]            w_shadow_next [NUM_DIGITS];
  logic [63:0]           w_shadow_flat;
  logic [63:0]           w_active_flat;
  logic [7:0]            w_byte;
  logic [7:0]            w_seg_dec;
  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_unused;

  // Only the word offset HADDR[4:2] is decoded. HSIZE is ignored because all transfers are words.
  assign w_unused  = ^{HSIZE, HADDR[31:5], HADDR[1:0]};
  assign HREADYOUT = 1'b1;
  assign Seg       = r_seg;
  assign nDigit    = r_ndigit;

  assign w_wr     = r_dp_valid &  r_dp_write;
  assign w_rd     = r_dp_valid & ~r_dp_write;
  assign w_wrap   = r_en && (r_presc == PRESC_LAST) && (r_index == LAST_DIGIT);
  assign w_commit = r_pending && (!r_en || w_wrap);
  assign w_on     = r_en && (r_pwm <= r_bright);

  // Capture the address phase of every transfer that targets this slave
  // NOTE: sequential state uses <= so each register samples only pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      r_dp_valid <= HREADY && HSEL && (HTRANS != 2'b00);
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[4:2];
    end
  end

  // Shadow contents after this cycle's write. A commit copies this value, so a write in the same cycle is included.
  // NOTE: always_comb assigns a default first, so no path can infer a latch.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_shadow_next[k] = r_shadow[k];
      if (w_wr && r_dp_addr == ((k < 4) ? ADDR_DATA_LO : ADDR_DATA_HI))
        w_shadow_next[k] = HWDATA[8*(k%4) +: 8];
    end
  end

  // Pack shadow and active bytes into 8-byte vectors, with unimplemented digits reading 0
  always_comb begin
    w_shadow_flat = '0;
    w_active_flat = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_shadow_flat[8*k +: 8] = r_shadow[k];
      w_active_flat[8*k +: 8] = r_active[k];
    end
  end

  // Read mux, driven only while a read data phase is in progress
  always_comb begin
    HRDATA = '0;
    if (w_rd) begin
      case (r_dp_addr)
        ADDR_CTRL:    HRDATA = {16'd0, r_hexmask, 7'd0, r_en};
        ADDR_STATUS:  HRDATA = {20'd0, 4'(NUM_DIGITS), 1'b0, r_index, 3'd0, r_pending};
        ADDR_BRIGHT:  HRDATA = {28'd0, r_bright};
        ADDR_DATA_LO: HRDATA = w_shadow_flat[31:0];
        ADDR_DATA_HI: HRDATA = w_shadow_flat[63:32];
        default:      HRDATA = '0;
      endcase
    end
  end

  // Register writes, commit request, and the frame-synchronous shadow-to-active copy
  // NOTE: the byte arrays are reset explicitly, so a reset discards any half-built or pending frame.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_en      <= 1'b0;
      r_hexmask <= '0;
      r_bright  <= 4'hF;
      r_pending <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (w_wr && r_dp_addr == ADDR_CTRL) begin
        r_en      <= HWDATA[0];
        r_hexmask <= HWDATA[15:8] & DIGIT_MASK;
      end
      if (w_wr && r_dp_addr == ADDR_BRIGHT)
        r_bright <= HWDATA[3:0];
      for (int k = 0; k < NUM_DIGITS; k++)
        r_shadow[k] <= w_shadow_next[k];
      if (w_commit) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          r_active[k] <= w_shadow_next[k];
        r_pending <= 1'b0;
      end else if (w_wr && r_dp_addr == ADDR_CTRL && HWDATA[1]) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Scan prescaler, digit index and free-running PWM counter
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_presc <= '0;
      r_index <= '0;
      r_pwm   <= '0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (!r_en) begin
        r_presc <= '0;
        r_index <= '0;
      end else if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_index <= (r_index == LAST_DIGIT) ? 3'd0 : r_index + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign w_byte    = w_active_flat[{r_index, 3'b000} +: 8];
  assign w_seg_dec = r_hexmask[r_index] ? {w_byte[7], FONT[w_byte[3:0]]} : w_byte;
  assign w_sel     = ~(NUM_DIGITS'(1) << r_index);

  // Registered pin drivers, blanked whenever the display is disabled or in the PWM off time
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_seg    <= '0;
      r_ndigit <= '1;
    end else if (w_on) begin
      r_seg    <= w_seg_dec;
      r_ndigit <= w_sel;
    end else begin
      r_seg    <= '0;
      r_ndigit <= '1;
    end
  end

endmodule

// File: tb/tb_ahb_seg_display.sv
// Bench for ahb_seg_display. It runs a 4-digit and a 6-digit instance on one
// shared bus. Both are compared every cycle against a cycle-level model that is
// built on scan/PWM time counters. Directed checks cover the documented scenarios.
module tb_ahb_seg_display;

  localparam int RD = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HSEL;

  logic [31:0] hrdata_a, hrdata_b;
  logic        hreadyout_a, hreadyout_b;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  nd_a;
  logic [5:0]  nd_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_seg_display #(.NUM_DIGITS(4), .REFRESH_DIV(RD)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
    .HRDATA(hrdata_a), .HREADYOUT(hreadyout_a), .Seg(seg_a), .nDigit(nd_a)
  );

  ahb_seg_display #(.NUM_DIGITS(6), .REFRESH_DIV(RD)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
    .HRDATA(hrdata_b), .HREADYOUT(hreadyout_b), .Seg(seg_b), .nDigit(nd_b)
  );

  // ---------------- reference model ----------------
  int         nd_of [2] = '{4, 6};
  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit         m_en [2];
  logic [7:0] m_hex [2];
  logic [3:0] m_bright [2];
  bit         m_pend [2];
  int         m_encnt [2];   // enabled cycles, taken mod one frame
  logic [7:0] m_sh [2][8];
  logic [7:0] m_act [2][8];
  logic [7:0] m_seg [2];
  logic [7:0] m_nd [2];
  bit         m_aval, m_awr;
  logic [2:0] m_aidx;
  int         m_cyc;         // cycles since reset, mod 16 (the PWM phase)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
    logic [31:0] r = '0;
    int n = nd_of[i];
    int base = (a == 3'd5) ? 4 : 0;
    case (a)
      3'd0: r = 32'(m_hex[i]) * 256 + 32'(m_en[i]);
      3'd1: r = 32'(m_pend[i]) + 32'((m_encnt[i] / RD) % n) * 16 + 32'(n) * 256;
      3'd2: r = 32'(m_bright[i]);
      3'd4, 3'd5:
        for (int k = 0; k < 4; k++)
          if (base + k < n) r[8*k +: 8] = m_sh[i][base + k];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge(input int i);
    int         n    = nd_of[i];
    logic [7:0] mask = 8'((1 << n) - 1);
    logic [7:0] sh_new [8];
    logic [7:0] b;
    int         idx;
    bit         on, wr, commit;
    if (HRESET) begin
      m_en[i] = 0; m_hex[i] = '0; m_bright[i] = 4'hF; m_pend[i] = 0; m_encnt[i] = 0;
      for (int k = 0; k < 8; k++) begin m_sh[i][k] = '0; m_act[i][k] = '0; end
      m_seg[i] = '0; m_nd[i] = mask;
      return;
    end
    idx = (m_encnt[i] / RD) % n;
    on  = m_en[i] && (m_cyc <= int'(m_bright[i]));
    b   = m_act[i][idx];
    m_seg[i] = !on ? 8'h00 : (m_hex[i][idx] ? {b[7], font_tab[b[3:0]]} : b);
    m_nd[i]  = !on ? mask  : (mask & ~(8'd1 << idx));
    wr = m_aval && m_awr;
    for (int k = 0; k < 8; k++) sh_new[k] = m_sh[i][k];
    for (int k = 0; k < n; k++)
      if (wr && m_aidx == ((k < 4) ? 3'd4 : 3'd5)) sh_new[k] = HWDATA[8*(k%4) +: 8];
    commit = m_pend[i] && (!m_en[i] || m_encnt[i] == RD * n - 1);
    if (commit) begin
      for (int k = 0; k < 8; k++) m_act[i][k] = sh_new[k];
      m_pend[i] = 0;
    end else if (wr && m_aidx == 3'd0 && HWDATA[1]) begin
      m_pend[i] = 1;
    end
    for (int k = 0; k < 8; k++) m_sh[i][k] = sh_new[k];
    m_encnt[i] = m_en[i] ? (m_encnt[i] + 1) % (RD * n) : 0;
    if (wr && m_aidx == 3'd0) begin
      m_en[i]  = HWDATA[0];
      m_hex[i] = HWDATA[15:8] & mask;
    end
    if (wr && m_aidx == 3'd2) m_bright[i] = HWDATA[3:0];
  endtask

  // One clock: advance the model on the edge, then compare every output 1 ns later
  task automatic step();
    @(posedge HCLK);
    for (int i = 0; i < 2; i++) model_edge(i);
    if (HRESET) begin
      m_aval = 0; m_awr = 0; m_aidx = '0; m_cyc = 0;
    end else begin
      m_aval = HREADY && HSEL && (HTRANS != 2'b00);
      m_awr  = HWRITE;
      m_aidx = HADDR[4:2];
      m_cyc  = (m_cyc + 1) % 16;
    end
    #1;
    check("seg_a",    32'(seg_a), 32'(m_seg[0]));
    check("ndigit_a", 32'(nd_a),  32'(m_nd[0][3:0]));
    check("seg_b",    32'(seg_b), 32'(m_seg[1]));
    check("ndigit_b", 32'(nd_b),  32'(m_nd[1][5:0]));
    check("hrdata_a", hrdata_a, (m_aval && !m_awr) ? model_read(0, m_aidx) : 32'd0);
    check("hrdata_b", hrdata_b, (m_aval && !m_awr) ? model_read(1, m_aidx) : 32'd0);
  endtask

  // ---------------- bus helpers ----------------
  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'd0, a, 2'b00};
    step();
    bus_idle(); HWDATA = d;
    step();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d0, output logic [31:0] d1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'd0, a, 2'b00};
    step();
    d0 = hrdata_a; d1 = hrdata_b;
    bus_idle();
  endtask

  // Bounded wait for a given digit/segment pattern on the 4-digit instance
  task automatic wait_pat(input string tag, input logic [3:0] nd, input logic [7:0] sg);
    int n = 0;
    while (!(nd_a == nd && seg_a == sg) && n < 100) begin step(); n++; end
    check(tag, {20'd0, nd_a, seg_a}, {20'd0, nd, sg});
  endtask

  // Expect a full 16-cycle frame of four digits (each held 4 cycles), then digit 0 again
  task automatic expect_frame(input string tag, input logic [31:0] segs);
    logic [3:0] nd;
    wait_pat({tag, "_start"}, 4'b1110, segs[7:0]);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      nd = ~(4'd1 << ((c / 4) % 4));
      check({tag, "_nd"},  32'(nd_a),  32'(nd));
      check({tag, "_seg"}, 32'(seg_a), 32'(segs[8*((c/4)%4) +: 8]));
    end
  endtask

  initial begin
    logic [31:0] d0, d1, pat, data;
    logic [2:0]  a;
    int          max0, max1, runs, lit;
    logic [2:0]  addr_tab [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd5, 3'd5, 3'd3, 3'd7};

    HRESET = 1'b1; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HREADY = 1'b1;
    bus_idle();
    step(); step();
    HRESET = 1'b0;

    // Reset state
    check("rst_ndigit", 32'(nd_a), 32'hF);
    check("rst_seg",    32'(seg_a), 32'h0);
    check("hreadyout",  32'(hreadyout_a & hreadyout_b), 32'h1);
    bus_read(3'd1, d0, d1);
    check("rst_status_a", d0, 32'h0000_0400);
    check("rst_status_b", d1, 32'h0000_0600);
    bus_read(3'd2, d0, d1);
    check("rst_bright", d0, 32'h0000_000F);
    bus_read(3'd0, d0, d1);
    check("rst_ctrl", d0, 32'h0);

    // First commit: pending until the wrap, then raw bytes scan across the digits
    bus_write(3'd4, 32'h4F5B063F);
    bus_write(3'd0, 32'h3);
    bus_read(3'd1, d0, d1);
    check("pending_set", 32'(d0[0]), 32'h1);
    expect_frame("raw_frame", 32'h4F5B063F);

    // Tear-free update requested during the digit-1 slot
    wait_pat("slot1", 4'b1101, 8'h06);
    bus_write(3'd4, 32'h7F7F7F7F);
    bus_write(3'd0, 32'h3);
    bus_read(3'd1, d0, d1);
    check("pend_before_wrap", 32'(d0[0]), 32'h1);
    wait_pat("old_digit2", 4'b1011, 8'h5B);
    wait_pat("old_digit3", 4'b0111, 8'h4F);
    wait_pat("new_digit0", 4'b1110, 8'h7F);
    bus_read(3'd1, d0, d1);
    check("pend_after_wrap", 32'(d0[0]), 32'h0);

    // Hex-font mode on all four digits, with the DP bit passed through
    bus_write(3'd4, 32'h8A030201);
    bus_write(3'd0, 32'h0F03);
    expect_frame("hex_frame", 32'hF74F5B06);

    // Brightness 3: four lit cycles per 16-cycle PWM window, in one run
    bus_write(3'd2, 32'h3);
    pat = '0;
    for (int c = 0; c < 32; c++) begin
      step();
      pat[c] = (nd_a != 4'hF);
    end
    check("bright_window", 32'($countones(pat[15:0])), 32'd4);
    runs = 0;
    for (int c = 0; c < 32; c++) if (pat[c] && !pat[(c + 31) % 32]) runs++;
    check("bright_runs", 32'(runs), 32'd2);
    bus_write(3'd2, 32'hF);

    // The digit index wraps at NUM_DIGITS-1 on each instance
    max0 = 0; max1 = 0;
    for (int r = 0; r < 60; r++) begin
      bus_read(3'd1, d0, d1);
      if (int'(d0[6:4]) > max0) max0 = int'(d0[6:4]);
      if (int'(d1[6:4]) > max1) max1 = int'(d1[6:4]);
    end
    check("max_index_4", 32'(max0), 32'd3);
    check("max_index_6", 32'(max1), 32'd5);

    // Randomised traffic, including ignored transfers and back-off gaps
    for (int it = 0; it < 300; it++) begin
      int r = $urandom_range(0, 99);
      a    = addr_tab[$urandom_range(0, 9)];
      data = $urandom;
      if (r < 8) begin
        HSEL = 1'($urandom_range(0, 1)); HTRANS = 2'($urandom_range(0, 3));
        HREADY = 1'($urandom_range(0, 1)); HWRITE = 1'b1; HADDR = $urandom;
        if (HSEL && HREADY && HTRANS != 2'b00) HREADY = 1'b0;
        step();
        HREADY = 1'b1; bus_idle(); HWDATA = $urandom;
        step();
      end else if (r < 60) begin
        if (a == 3'd0) begin
          data = data & 32'h0000FF03;
          data[0] = ($urandom_range(0, 99) < 85);
        end
        bus_write(a, data);
      end else begin
        bus_read(a, d0, d1);
      end
      repeat ($urandom_range(0, 3)) step();
    end

    // Disable with commit: blank two cycles after the address phase, pending clears next cycle
    bus_write(3'd5, 32'h11223344);
    bus_write(3'd0, 32'h2);
    step();
    check("dis_ndigit_a", 32'(nd_a), 32'hF);
    check("dis_ndigit_b", 32'(nd_b), 32'h3F);
    bus_read(3'd1, d0, d1);
    check("dis_pend_a", 32'(d0[0]), 32'h0);
    check("dis_pend_b", 32'(d1[0]), 32'h0);
    bus_write(3'd5, 32'h12345678);
    bus_read(3'd5, d0, d1);
    check("data_hi_4dig", d0, 32'h0);
    check("data_hi_6dig", d1, 32'h0000_5678);

    // Reset while a commit is pending discards it
    bus_write(3'd0, 32'h1);
    bus_write(3'd4, 32'hFFFFFFFF);
    bus_write(3'd0, 32'h3);
    step();
    HRESET = 1'b1; step(); HRESET = 1'b0;
    bus_write(3'd0, 32'h1);
    lit = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (seg_a != 8'h00) lit++;
    end
    check("rst_discard_seg", 32'(lit), 32'd0);
    bus_read(3'd4, d0, d1);
    check("rst_discard_shadow", d0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_seg_display.md
Name: ahb_seg_display

Overview:
- AHB-Lite slave that drives a multiplexed 7-segment display with a parametrised digit count and a programmable scan rate.
- Each digit can be in raw-segment mode or hex-font mode, and display brightness is set by PWM.
- Data writes land in shadow registers and are copied to the display only on COMMIT, at a frame boundary, so a partial update is never shown.
- Sits on the M0 AHB-Lite bus behind the decoder. Outputs go straight to the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_DIV, 1024, HCLK cycles each digit stays selected (>=2).

Ports:
- HCLK  input  1  bus clock; the only clock.
- HRESET  input  1  synchronous, active-high reset.
- HADDR  input  32  address; only [4:2] decoded.
- HWDATA  input  32  write data.
- HSIZE  input  3  ignored; word transfers only.
- HTRANS  input  2  transfer type.
- HWRITE  input  1  write strobe.
- HREADY  input  1  bus ready.
- HSEL  input  1  slave select.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  tied 1; zero wait states.
- Seg  output  8  {DP,G,F,E,D,C,B,A}, active-high.
- nDigit  output  NUM_DIGITS  digit select, active-low, one-hot-low.

Behaviour:
- Bus interface:
  - Address phase is captured when HREADY && HSEL && HTRANS!=IDLE.
  - Write data is applied in the data phase (next cycle).
  - Read data is combinational from the captured address. HRDATA=0 when no read is active.
- Register map, by HADDR[4:2]:
  - 0 CTRL (RW), reset 0:
    - bit0 EN.
    - bit1 COMMIT: write-1 sets pending; always reads 0.
    - [15:8] HEXMASK: bit k selects hex mode for digit k. Bits >= NUM_DIGITS are forced to 0.
  - 1 STATUS (RO; writes ignored):
    - bit0 PENDING.
    - [6:4] current digit index.
    - [11:8] NUM_DIGITS.
  - 2 BRIGHT (RW): [3:0], reset 0xF.
  - 4 DATA_LO (RW shadow): byte k is digit k, k = 0..3.
  - 5 DATA_HI (RW shadow): byte k is digit 4+k.
  - Shadow bytes for digits >= NUM_DIGITS read 0 and ignore writes.
  - All other offsets read 0; writes to them are ignored.
- Commit:
  - PENDING is set in the data phase of a CTRL write with bit1=1.
  - When EN=1, shadow is copied to the active registers on the cycle the digit index wraps NUM_DIGITS-1 -> 0, and PENDING clears on that same edge.
  - When EN=0, the copy and clear happen on the next cycle.
  - A shadow write while PENDING is set is included in that copy.
  - A second COMMIT while pending has no extra effect.
- Scanning, when EN=1:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count, index advances (wraps at NUM_DIGITS-1).
  - When EN=0, prescaler and index are held at 0.
- 4-bit PWM counter free-runs every cycle, wrapping 15 -> 0. Display is on when EN && pwm <= BRIGHT.
- Pin outputs are registered, one cycle after index/pwm:
  - When on: nDigit = ~(1<<index) and Seg = decode(active byte[index]).
  - Otherwise: nDigit all 1s and Seg = 0.
- Decode:
  - Raw mode: Seg = byte.
  - Hex mode: Seg[6:0] = font(byte[3:0]), Seg[7] = byte[7].
  - Font 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Reset:
  - CTRL=0, BRIGHT=F, shadow/active=0, PENDING=0.
  - Counters=0, nDigit all 1s, Seg=0, HRDATA=0.
  - Reset mid-frame or mid-pending discards everything: no commit occurs.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless stated):
- Reset -> nDigit=1111, Seg=00; STATUS reads 0x00000400; BRIGHT reads 0x0000000F; CTRL reads 0.
- Write DATA_LO=0x4F5B063F, then CTRL=0x3 -> PENDING=1 until the wrap. Then each digit holds for 4 cycles:
  - nDigit 1110/Seg 3F, 1101/06, 1011/5B, 0111/4F.
  - Frame period is 16 cycles.
- CTRL=0x0F03, DATA_LO=0x8A030201 -> Seg 06, 5B, 4F, F7 for digits 0-3.
- Tear-free update:
  - During the digit-1 slot, write DATA_LO=0x7F7F7F7F and COMMIT.
  - Digits 2 and 3 still show old values; digit 0 of the next frame shows 7F.
  - STATUS bit0 reads 1 before the wrap and 0 after.
- BRIGHT=3 -> in every 16-cycle PWM window, outputs are active for 4 consecutive cycles and blank (nDigit=1111, Seg=00) for 12.
- Disable and commit:
  - Write CTRL=0x2 (EN=0, COMMIT) -> 2 cycles later nDigit=1111; PENDING clears the next cycle; DATA_HI writes are ignored.
  - With NUM_DIGITS=6, index wraps after 5.
